// File: rtl/bcd_to_seven_segment_if.sv
// Digit-side signal bundle for one bcd_to_seven_segment instance.
// master drives the code and display controls; slave is the decoder.
interface bcd_to_seven_segment_if;
  logic [3:0] bcd;
  logic       lamp_test;
  logic       blank;
  logic       rb_in;
  logic [6:0] seg;
  logic       rb_out;
  logic       err;

  modport master (
    output bcd, lamp_test, blank, rb_in,
    input  seg, rb_out, err
  );

  modport slave (
    input  bcd, lamp_test, blank, rb_in,
    output seg, rb_out, err
  );
endinterface

// File: rtl/bcd_to_seven_segment.sv
// Registered BCD-to-seven-segment decoder with lamp test, blanking and ripple blanking.
// Define HEX_DIGITS_EN to show codes 10-15 as hex letters instead of flagging err.
module bcd_to_seven_segment (
  input  logic                          clk,
  input  logic                          rst_n,
  bcd_to_seven_segment_if.slave         bus_io
);

  logic [6:0] seg_d, seg_q;
  logic       rb_d, rb_q;
  logic       err_d, err_q;
  logic [6:0] glyph;
  logic       zero;

  assign zero = (bus_io.bcd == 4'd0);

  always_comb begin
    glyph = 7'h00;
    err_d = 1'b0;
    case (bus_io.bcd)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
`ifdef HEX_DIGITS_EN
      4'd10:   glyph = 7'h77;
      4'd11:   glyph = 7'h7C;
      4'd12:   glyph = 7'h39;
      4'd13:   glyph = 7'h5E;
      4'd14:   glyph = 7'h79;
      default: glyph = 7'h71;
`else
      default: begin
        glyph = 7'h00;
        err_d = 1'b1;
      end
`endif
    endcase
  end

  always_comb begin
    seg_d = glyph;
    if (bus_io.lamp_test) begin
      seg_d = 7'h7F;
    end else if (bus_io.blank) begin
      seg_d = 7'h00;
    end else if (bus_io.rb_in && zero) begin
      seg_d = 7'h00;
    end
    // blank deliberately does not break the ripple chain
    rb_d = bus_io.rb_in & zero & ~bus_io.lamp_test;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h00;
      rb_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      rb_q  <= rb_d;
      err_q <= err_d;
    end
  end

  assign bus_io.seg    = seg_q;
  assign bus_io.rb_out = rb_q;
  assign bus_io.err    = err_q;

endmodule

// File: tb/tb_bcd_to_seven_segment.sv
// Self-checking bench: two chained digits, directed plus random codes against a table model.
module tb_bcd_to_seven_segment;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [6:0] font [16];

  bcd_to_seven_segment_if msd_if ();
  bcd_to_seven_segment_if lsd_if ();

  assign lsd_if.rb_in = msd_if.rb_out;

  bcd_to_seven_segment u_msd (.clk(clk), .rst_n(rst_n), .bus_io(msd_if));
  bcd_to_seven_segment u_lsd (.clk(clk), .rst_n(rst_n), .bus_io(lsd_if));

  always #5 clk = ~clk;

  function automatic logic hex_en();
`ifdef HEX_DIGITS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: returns {err, rb_out, seg} expected one cycle after sampling.
  function automatic logic [8:0] model(input logic [3:0] b, input logic lt, input logic bl,
                                       input logic rb);
    logic [6:0] s;
    logic       r, e;
    if (b < 10) s = font[b];
    else        s = hex_en() ? font[b] : 7'h00;
    e = (b > 9) && !hex_en();
    r = rb && (b == 0) && !lt;
    if (lt)                 s = 7'h7F;
    else if (bl)            s = 7'h00;
    else if (rb && b == 0)  s = 7'h00;
    return {e, r, s};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_msd(input string tag, input logic [8:0] exp);
    check({tag, ".seg"}, msd_if.seg, exp[6:0]);
    check({tag, ".rb_out"}, {6'd0, msd_if.rb_out}, {6'd0, exp[7]});
    check({tag, ".err"}, {6'd0, msd_if.err}, {6'd0, exp[8]});
  endtask

  // Apply one code away from the edge, then check one cycle later.
  task automatic step(input string tag, input logic [3:0] b, input logic lt, input logic bl,
                      input logic rb);
    @(negedge clk);
    msd_if.bcd = b; msd_if.lamp_test = lt; msd_if.blank = bl; msd_if.rb_in = rb;
    @(posedge clk); #1;
    check_msd(tag, model(b, lt, bl, rb));
  endtask

  initial begin
    logic [3:0] rb_b;
    logic [8:0] e_msd, e_lsd;
    font[0] = 7'h3F; font[1] = 7'h06; font[2] = 7'h5B; font[3] = 7'h4F;
    font[4] = 7'h66; font[5] = 7'h6D; font[6] = 7'h7D; font[7] = 7'h07;
    font[8] = 7'h7F; font[9] = 7'h6F; font[10] = 7'h77; font[11] = 7'h7C;
    font[12] = 7'h39; font[13] = 7'h5E; font[14] = 7'h79; font[15] = 7'h71;

    msd_if.bcd = 4'd8; msd_if.lamp_test = 1'b0; msd_if.blank = 1'b0; msd_if.rb_in = 1'b0;
    lsd_if.bcd = 4'd0; lsd_if.lamp_test = 1'b0; lsd_if.blank = 1'b0;

    repeat (2) @(posedge clk);
    #1 check_msd("reset_hold", 9'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_msd("first_decode", 9'h07F);

    // Mid-stream asynchronous reset with bcd=8 still applied
    #2 rst_n = 1'b0;
    #1 check_msd("async_reset", 9'd0);
    @(posedge clk); #1;
    check_msd("reset_held", 9'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_msd("reset_release", 9'h07F);

    for (int i = 0; i < 16; i++) step($sformatf("sweep%0d", i), 4'(i), 1'b0, 1'b0, 1'b0);

    step("lt_over_blank", 4'd3, 1'b1, 1'b1, 1'b0);
    step("lt_over_ripple", 4'd0, 1'b1, 1'b0, 1'b1);
    step("blank", 4'd5, 1'b0, 1'b1, 1'b0);
    step("unblank", 4'd5, 1'b0, 1'b0, 1'b0);
    step("blank_keeps_rb", 4'd0, 1'b0, 1'b1, 1'b1);
    step("invalid12", 4'd12, 1'b0, 1'b0, 1'b0);
    step("after_invalid", 4'd2, 1'b0, 1'b0, 1'b0);
    step("invalid_lt", 4'd14, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      step($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Ripple chain; hold each pair two cycles so the registered rb reaches the LSD.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      msd_if.lamp_test = 1'b0; msd_if.blank = 1'b0; msd_if.rb_in = 1'b1;
      case (k)
        0: begin msd_if.bcd = 4'd0; lsd_if.bcd = 4'd7; end
        1: begin msd_if.bcd = 4'd0; lsd_if.bcd = 4'd0; end
        default: begin msd_if.bcd = 4'd4; lsd_if.bcd = 4'd0; end
      endcase
      rb_b = lsd_if.bcd;
      repeat (2) @(posedge clk);
      #1;
      e_msd = model(msd_if.bcd, 1'b0, 1'b0, 1'b1);
      e_lsd = model(rb_b, 1'b0, 1'b0, e_msd[7]);
      check_msd($sformatf("chain%0d_msd", k), e_msd);
      check($sformatf("chain%0d_lsd.seg", k), lsd_if.seg, e_lsd[6:0]);
      check($sformatf("chain%0d_lsd.rb_out", k), {6'd0, lsd_if.rb_out}, {6'd0, e_lsd[7]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
